// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module     : spi_controller
// Description: SPI mode-0 initiator that serialises 16-bit {rw, addr, data}
//              frames. Optional readback via macro SPI_CTRL_READBACK_EN.
// Revision   : 1.0
// ============================================================================
module spi_controller #(
  parameter int CLK_DIV        = 4,
  parameter int CS_IDLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       frame_done,
`ifdef SPI_CTRL_READBACK_EN
  input  logic       miso,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
`endif
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(CS_IDLE_CYCLES - 1);

  generate
    if (CLK_DIV < 3 || CS_IDLE_CYCLES < 4) begin : g_param_check
      $error("spi_controller: CLK_DIV must be >= 3 and CS_IDLE_CYCLES >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           r_state,   w_state;
  logic [DIV_W-1:0] r_div_cnt, w_div_cnt;
  logic [3:0]       r_bit_cnt, w_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt;
  logic             r_high,    w_high;
  logic [15:0]      r_shift,   w_shift;
  logic             r_sclk,    w_sclk;
  logic             r_mosi,    w_mosi;
  logic             r_cs_n,    w_cs_n;
  logic             r_done,    w_done;
  logic             r_ready;
  logic             r_busy;
  logic             w_div_end;
  logic [3:0]       w_bit_m1;

`ifdef SPI_CTRL_READBACK_EN
  logic [7:0]       r_rx,        w_rx;
  logic             r_rsp_valid, w_rsp_valid;
  logic [7:0]       r_rsp_rdata, w_rsp_rdata;
`endif

  assign w_div_end = (r_div_cnt == c_div_last);
  assign w_bit_m1  = r_bit_cnt - 4'd1;

  // Next-state logic also computes the next value of every SPI output so that
  // the pins come straight from flops.
  always_comb begin
    w_state   = r_state;
    w_div_cnt = r_div_cnt;
    w_bit_cnt = r_bit_cnt;
    w_gap_cnt = r_gap_cnt;
    w_high    = r_high;
    w_shift   = r_shift;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;
    w_cs_n    = r_cs_n;
    w_done    = 1'b0;
`ifdef SPI_CTRL_READBACK_EN
    w_rx        = r_rx;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
`endif
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state   = S_SETUP;
          w_shift   = {req_write, req_addr, req_wdata};
          w_mosi    = req_write;
          w_cs_n    = 1'b0;
          w_sclk    = 1'b0;
          w_div_cnt = '0;
        end
      end
      S_SETUP: begin
        if (w_div_end) begin
          w_state   = S_SHIFT;
          w_div_cnt = '0;
          w_sclk    = 1'b1;
          w_high    = 1'b1;
          w_bit_cnt = 4'd15;
        end else begin
          w_div_cnt = r_div_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!w_div_end) begin
          w_div_cnt = r_div_cnt + 1'b1;
        end else if (r_high) begin
          // Falling edge: present the next bit; bit 0 is held as CS hold time.
          w_div_cnt = '0;
          w_high    = 1'b0;
          w_sclk    = 1'b0;
          if (r_bit_cnt != 4'd0) begin
            w_mosi = r_shift[w_bit_m1];
          end
`ifdef SPI_CTRL_READBACK_EN
          w_rx = {r_rx[6:0], miso};
`endif
        end else if (r_bit_cnt == 4'd0) begin
          w_state   = S_GAP;
          w_div_cnt = '0;
          w_gap_cnt = '0;
          w_cs_n    = 1'b1;
          w_mosi    = 1'b0;
          w_done    = 1'b1;
`ifdef SPI_CTRL_READBACK_EN
          if (!r_shift[15]) begin
            w_rsp_valid = 1'b1;
            w_rsp_rdata = r_rx;
          end
`endif
        end else begin
          w_div_cnt = '0;
          w_high    = 1'b1;
          w_sclk    = 1'b1;
          w_bit_cnt = w_bit_m1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_gap_last) begin
          w_state = S_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_high    <= 1'b0;
      r_shift   <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
`ifdef SPI_CTRL_READBACK_EN
      r_rx        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_div_cnt <= w_div_cnt;
      r_bit_cnt <= w_bit_cnt;
      r_gap_cnt <= w_gap_cnt;
      r_high    <= w_high;
      r_shift   <= w_shift;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
      r_cs_n    <= w_cs_n;
      r_done    <= w_done;
      r_ready   <= (w_state == S_IDLE);
      r_busy    <= (w_state != S_IDLE);
`ifdef SPI_CTRL_READBACK_EN
      r_rx        <= w_rx;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
`endif
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign sclk       = r_sclk;
  assign mosi       = r_mosi;
  assign cs_n       = r_cs_n;
`ifdef SPI_CTRL_READBACK_EN
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module     : tb_spi_controller
// Description: Frames on two controller configurations checked against a
//              frame-level reference model of the wire protocol.
// Revision   : 1.0
// ============================================================================
module tb_spi_controller;

  localparam int D_A = 4;
  localparam int G_A = 8;
  localparam int D_B = 3;
  localparam int G_B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       valid_a, ready_a, write_a, busy_a, done_a, sclk_a, mosi_a, cs_n_a;
  logic [6:0] addr_a;
  logic [7:0] wdata_a;
  logic       valid_b, ready_b, write_b, busy_b, done_b, sclk_b, mosi_b, cs_n_b;
  logic [6:0] addr_b;
  logic [7:0] wdata_b;
`ifdef SPI_CTRL_READBACK_EN
  logic       miso = 1'b0;
  logic       rsp_valid_a, rsp_valid_b;
  logic [7:0] rsp_rdata_a, rsp_rdata_b;
  logic [7:0] last_rd_a = 8'h00;
  logic [7:0] last_rd_b = 8'h00;
`endif

  spi_controller #(.CLK_DIV(D_A), .CS_IDLE_CYCLES(G_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(write_a), .req_addr(addr_a), .req_wdata(wdata_a),
    .busy(busy_a), .frame_done(done_a),
`ifdef SPI_CTRL_READBACK_EN
    .miso(miso), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
`endif
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a)
  );

  spi_controller #(.CLK_DIV(D_B), .CS_IDLE_CYCLES(G_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(write_b), .req_addr(addr_b), .req_wdata(wdata_b),
    .busy(busy_b), .frame_done(done_b),
`ifdef SPI_CTRL_READBACK_EN
    .miso(miso), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
`endif
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b)
  );

  // sel chooses which instance the directed steps talk to
  bit   sel = 1'b0;
  logic m_sclk, m_mosi, m_cs_n, m_ready, m_busy, m_done;
  assign m_sclk  = sel ? sclk_b  : sclk_a;
  assign m_mosi  = sel ? mosi_b  : mosi_a;
  assign m_cs_n  = sel ? cs_n_b  : cs_n_a;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
`ifdef SPI_CTRL_READBACK_EN
  logic       m_rsp_valid;
  logic [7:0] m_rsp_rdata;
  assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign m_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic       nxt_w;
  logic [6:0] nxt_a;
  logic [7:0] nxt_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [6:0] a, input logic [7:0] d);
    if (sel) begin
      valid_b = v; write_b = w; addr_b = a; wdata_b = d;
    end else begin
      valid_a = v; write_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  // Called at a negedge with the selected instance idle. Expected behaviour is
  // derived from the frame rules: 16 MSB-first bits, cs_n low 33*D cycles,
  // frame_done at T0+33*D+1, ready again at T0+1+33*D+G.
  task automatic run_frame(input logic w, input logic [6:0] a, input logic [7:0] d,
                           input logic [7:0] rd, input bit keep_valid, input string tag);
    int D, G, waitc, rises, cs_low, cs_tail, done_cnt, done_k, ready_k, busy_bad, idle_bad;
    int rsp_cnt, rsp_k;
    logic [15:0] word;
    logic prev_sclk, prev_mosi;
    bit stable_ok;
    D = sel ? D_B : D_A;
    G = sel ? G_B : G_A;
    drive(1'b1, w, a, d);
    waitc = 0;
    while (m_ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check($sformatf("%s/accept_wait", tag), waitc, 0);
    rises = 0; cs_low = 0; cs_tail = 0; done_cnt = 0; done_k = -1; ready_k = -1;
    busy_bad = 0; idle_bad = 0; rsp_cnt = 0; rsp_k = -1; word = '0;
    prev_sclk = 1'b0; prev_mosi = w; stable_ok = 1'b1;
    for (int k = 1; k <= 1 + 33 * D + G; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (keep_valid) drive(1'b1, nxt_w, nxt_a, nxt_d);
        else drive(1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom));
      end
      if (k == 33 * D + 1 && !keep_valid) drive(1'b0, 1'($urandom), 7'($urandom), 8'($urandom));
      if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
        word = {word[14:0], m_mosi};
        if (m_mosi !== prev_mosi) stable_ok = 1'b0;
`ifdef SPI_CTRL_READBACK_EN
        miso = (rises >= 8) ? rd[15 - rises] : 1'($urandom);
`endif
        rises++;
      end
      if (m_cs_n === 1'b0) cs_low++;
      else if (cs_low > 0) cs_tail++;
      if (m_done === 1'b1) begin done_cnt++; done_k = k; end
      if (m_ready === 1'b1 && ready_k < 0) ready_k = k;
      if (m_busy === m_ready) busy_bad++;
      if (m_cs_n === 1'b1 && (m_sclk !== 1'b0 || m_mosi !== 1'b0)) idle_bad++;
`ifdef SPI_CTRL_READBACK_EN
      if (m_rsp_valid === 1'b1) begin rsp_cnt++; rsp_k = k; end
`endif
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
    end
    check($sformatf("%s/rises", tag), rises, 16);
    check($sformatf("%s/word", tag), word, {w, a, d});
    check($sformatf("%s/mosi_stable", tag), stable_ok, 1);
    check($sformatf("%s/cs_low", tag), cs_low, 33 * D);
    check($sformatf("%s/cs_high_tail", tag), cs_tail, G + 1);
    check($sformatf("%s/done_cnt", tag), done_cnt, 1);
    check($sformatf("%s/done_k", tag), done_k, 33 * D + 1);
    check($sformatf("%s/ready_k", tag), ready_k, 1 + 33 * D + G);
    check($sformatf("%s/busy_vs_ready", tag), busy_bad, 0);
    check($sformatf("%s/idle_lines", tag), idle_bad, 0);
`ifdef SPI_CTRL_READBACK_EN
    check($sformatf("%s/rsp_pulses", tag), rsp_cnt, w ? 0 : 1);
    if (!w) begin
      check($sformatf("%s/rsp_k", tag), rsp_k, 33 * D + 1);
      if (sel) last_rd_b = rd; else last_rd_a = rd;
    end
    check($sformatf("%s/rsp_rdata", tag), m_rsp_rdata, sel ? last_rd_b : last_rd_a);
`endif
  endtask

  task automatic reset_mid_frame();
    int rises, k;
    logic [15:0] word;
    logic prev;
    sel = 1'b0;
    drive(1'b1, 1'b1, 7'h01, 8'h3C);
    rises = 0; k = 0; word = '0; prev = 1'b0;
    while (rises < 7 && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) drive(1'b0, 1'b0, 7'h00, 8'h00);
      if (m_sclk === 1'b1 && prev === 1'b0) begin
        rises++;
        word = {word[14:0], m_mosi};
      end
      prev = m_sclk;
    end
    check("rstmid/prefix", word, 16'h813C >> 9);
    check("rstmid/sclk_before", m_sclk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid/async_idle", {m_sclk, m_mosi, m_cs_n, m_ready, m_busy, m_done}, 6'b001100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid/after_release", {m_sclk, m_mosi, m_cs_n, m_ready, m_busy, m_done}, 6'b001100);
`ifdef SPI_CTRL_READBACK_EN
    last_rd_a = 8'h00;
    last_rd_b = 8'h00;
    check("rstmid/rsp_cleared", {rsp_valid_a, rsp_rdata_a}, 9'h000);
`endif
  endtask

  initial begin
    logic       rw;
    logic [6:0] ra;
    logic [7:0] rdat, rrd;
    valid_a = 1'b0; write_a = 1'b0; addr_a = '0; wdata_a = '0;
    valid_b = 1'b0; write_b = 1'b0; addr_b = '0; wdata_b = '0;
    nxt_w = 1'b0; nxt_a = '0; nxt_d = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/a", {sclk_a, mosi_a, cs_n_a, ready_a, busy_a, done_a}, 6'b001100);
    check("reset/b", {sclk_b, mosi_b, cs_n_b, ready_b, busy_b, done_b}, 6'b001100);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset/a", {sclk_a, mosi_a, cs_n_a, ready_a, busy_a, done_a}, 6'b001100);

    sel = 1'b0;
    run_frame(1'b1, 7'h00, 8'hA5, 8'h00, 1'b0, "wr00_A5");

    nxt_w = 1'b1; nxt_a = 7'h02; nxt_d = 8'hFF;
    run_frame(1'b1, 7'h04, 8'h80, 8'h00, 1'b1, "b2b_first");
    run_frame(1'b1, 7'h02, 8'hFF, 8'h00, 1'b0, "b2b_second");

    run_frame(1'b1, 7'h05, 8'h12, 8'h00, 1'b0, "wr05_12");
    run_frame(1'b0, 7'h01, 8'h00, 8'hC3, 1'b0, "rd01");
    run_frame(1'b1, 7'h06, 8'h33, 8'h00, 1'b0, "wr_after_rd");

    sel = 1'b1;
    run_frame(1'b1, 7'h03, 8'h5A, 8'h00, 1'b0, "div3_wr03_5A");

    for (int i = 0; i < 10; i++) begin
      sel  = 1'($urandom);
      rw   = 1'($urandom);
      ra   = 7'($urandom);
      rdat = 8'($urandom);
      rrd  = 8'($urandom);
      run_frame(rw, ra, rdat, rrd, 1'b0, $sformatf("rand%0d", i));
    end

    reset_mid_frame();
    sel = 1'b0;
    run_frame(1'b1, 7'h01, 8'h3C, 8'h00, 1'b0, "recover");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
